joypad_port_multi: RTL and testbench

- Parametrised NES controller-port emulator: serves N player pads to the NES core's joypad strobe/clock interface.
- Adds per-pad autofire phase generation and open-bus fill after the last button bit.
- Tracks shift exhaustion per pad.
- Sits between the Dualshock decode logic (button vectors, active-high pressed) and the NES core, in the system clock domain.

---
 rtl/joypad_port_multi.sv | 88 ++++++++
 tb/tb_joypad_port_multi.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/joypad_port_multi.sv
// NES controller-port emulator for NUM_PADS pads with autofire and open-bus fill after the last button bit.
// Latency: a sampled pad_clk fall is visible on pad_data one cycle later; strobe reloads every cycle while high.
module joypad_port_multi #(
    parameter int               FREQ        = 25_000_000,
    parameter int               NUM_PADS    = 2,
    parameter int               BTN_W       = 8,
    parameter int               AUTOFIRE_HZ = 15,
    parameter logic [BTN_W-1:0] AF_MASK     = BTN_W'(2'b11),
    parameter logic             FILL_BIT    = 1'b1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_PADS*BTN_W-1:0] btn,
    input  logic [NUM_PADS*BTN_W-1:0] af_req,
    input  logic                      strobe,
    input  logic [NUM_PADS-1:0]       pad_clk,
    output logic [NUM_PADS-1:0]       pad_data,
    output logic [NUM_PADS-1:0]       pad_exhausted,
    output logic [NUM_PADS-1:0]       af_phase
);

    localparam int HP  = FREQ / (2 * AUTOFIRE_HZ);
    localparam int AFW = (HP > 1) ? $clog2(HP) : 1;
    localparam int RW  = $clog2(BTN_W + 1);

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        logic [BTN_W-1:0] shreg;
        logic [BTN_W-1:0] eff;
        logic [RW-1:0]    rd_cnt;
        logic [AFW-1:0]   af_cnt;
        logic             phase;
        logic             prev_act;
        logic             prev_clk;
        logic             act;
        logic             fall;

        assign act  = |(af_req[i*BTN_W +: BTN_W] & AF_MASK);
        assign eff  = btn[i*BTN_W +: BTN_W] | (af_req[i*BTN_W +: BTN_W] & AF_MASK & {BTN_W{phase}});
        assign fall = prev_clk & ~pad_clk[i];

        // A fresh request presses immediately, then the phase toggles every HP cycles.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                af_cnt   <= '0;
                phase    <= 1'b0;
                prev_act <= 1'b0;
            end else begin
                prev_act <= act;
                if (!act) begin
                    af_cnt <= '0;
                    phase  <= 1'b0;
                end else if (!prev_act) begin
                    af_cnt <= '0;
                    phase  <= 1'b1;
                end else if (af_cnt == AFW'(HP - 1)) begin
                    af_cnt <= '0;
                    phase  <= ~phase;
                end else begin
                    af_cnt <= af_cnt + 1'b1;
                end
            end
        end

        // Strobe wins over a coincident fall so a latch never loses fresh button state.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                shreg    <= '0;
                rd_cnt   <= '0;
                prev_clk <= 1'b0;
            end else begin
                prev_clk <= pad_clk[i];
                if (strobe) begin
                    shreg  <= eff;
                    rd_cnt <= '0;
                end else if (fall) begin
                    shreg <= {FILL_BIT, shreg[BTN_W-1:1]};
                    if (rd_cnt != RW'(BTN_W))
                        rd_cnt <= rd_cnt + 1'b1;
                end
            end
        end

        assign pad_data[i]      = shreg[0];
        assign pad_exhausted[i] = (rd_cnt == RW'(BTN_W));
        assign af_phase[i]      = phase;
    end

endmodule

// File: tb/tb_joypad_port_multi.sv
// Randomized and directed bench for joypad_port_multi against a read-index / elapsed-time reference model.
module tb_joypad_port_multi;

    localparam int         NP   = 2;
    localparam int         BW   = 8;
    localparam int         HP   = 10;
    localparam logic [7:0] MASK = 8'h03;
    localparam logic       FILL = 1'b1;

    logic          clk = 1'b0;
    logic          resetn;
    logic [15:0]   btn;
    logic [15:0]   af_req;
    logic          strobe;
    logic [1:0]    pad_clk;
    logic [1:0]    pad_data;
    logic [1:0]    pad_exhausted;
    logic [1:0]    af_phase;

    always #5 clk = ~clk;

    joypad_port_multi #(
        .FREQ(1000), .NUM_PADS(NP), .BTN_W(BW), .AUTOFIRE_HZ(50),
        .AF_MASK(MASK), .FILL_BIT(FILL)
    ) dut (
        .clk(clk), .resetn(resetn), .btn(btn), .af_req(af_req), .strobe(strobe),
        .pad_clk(pad_clk), .pad_data(pad_data), .pad_exhausted(pad_exhausted),
        .af_phase(af_phase)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference: the latched byte plus how many bits have been read, and time since autofire start.
    logic [7:0] m_loaded [NP];
    int         m_rd     [NP];
    int         m_t      [NP];
    logic       m_phase  [NP];
    logic       m_prev_act [NP];
    logic [1:0] m_prev_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_loaded[i] = '0; m_rd[i] = 0; m_t[i] = 0; m_phase[i] = 1'b0; m_prev_act[i] = 1'b0;
        end
        m_prev_clk = '0;
    endtask

    task automatic model_edge();
        for (int i = 0; i < NP; i++) begin
            logic [7:0] pb, pa, eff;
            logic act;
            pb  = btn[i*BW +: BW];
            pa  = af_req[i*BW +: BW] & MASK;
            act = |pa;
            eff = pb | (m_phase[i] ? pa : 8'h00);
            if (strobe) begin
                m_loaded[i] = eff;
                m_rd[i]     = 0;
            end else if (m_prev_clk[i] && !pad_clk[i]) begin
                m_rd[i] = (m_rd[i] < BW) ? m_rd[i] + 1 : BW;
            end
            if (!act) begin
                m_t[i] = 0; m_phase[i] = 1'b0;
            end else if (!m_prev_act[i]) begin
                m_t[i] = 0; m_phase[i] = 1'b1;
            end else begin
                m_t[i]++;
                m_phase[i] = ((m_t[i] / HP) % 2) == 0;
            end
            m_prev_act[i] = act;
        end
        m_prev_clk = pad_clk;
    endtask

    task automatic compare_all();
        logic [1:0] ed, ee, ep;
        for (int i = 0; i < NP; i++) begin
            ed[i] = (m_rd[i] < BW) ? m_loaded[i][m_rd[i]] : FILL;
            ee[i] = (m_rd[i] == BW);
            ep[i] = m_phase[i];
        end
        check("pad_data", 32'(pad_data), 32'(ed));
        check("pad_exhausted", 32'(pad_exhausted), 32'(ee));
        check("af_phase", 32'(af_phase), 32'(ep));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (resetn) model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic pulse(input logic [1:0] m);
        pad_clk = pad_clk | m;
        cycle();
        pad_clk = pad_clk & ~m;
        cycle();
    endtask

    task automatic latch();
        strobe = 1'b1;
        cycle();
        strobe = 1'b0;
        cycle();
    endtask

    initial begin
        logic [7:0] seq;
        resetn = 1'b0; btn = '0; af_req = '0; strobe = 1'b0; pad_clk = '0;
        model_reset();
        #3;
        check("reset_data", 32'(pad_data), 32'd0);
        check("reset_exh", 32'(pad_exhausted), 32'd0);
        check("reset_phase", 32'(af_phase), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Load and shift pad0 through all eight bits, then past the end.
        btn = 16'h0085;
        seq = 8'h85;
        latch();
        for (int k = 0; k < BW; k++) begin
            check("seq_bit", 32'(pad_data[0]), 32'(seq[k]));
            check("not_exh", 32'(pad_exhausted[0]), 32'd0);
            pulse(2'b01);
        end
        check("seq_fill", 32'(pad_data[0]), 32'(FILL));
        check("exhausted", 32'(pad_exhausted[0]), 32'd1);
        for (int k = 0; k < 3; k++) begin
            pulse(2'b01);
            check("overrun", 32'(pad_data[0]), 32'(FILL));
            check("overrun_exh", 32'(pad_exhausted[0]), 32'd1);
        end
        strobe = 1'b1;
        cycle();
        check("exh_clear", 32'(pad_exhausted[0]), 32'd0);
        strobe = 1'b0;
        cycle();

        // Autofire on a masked bit while strobe is held, then an unmasked request.
        btn = '0; af_req = 16'h0100; strobe = 1'b1;
        cycle();
        check("af_first", 32'(af_phase[1]), 32'd1);
        for (int k = 0; k < 45; k++) cycle();
        af_req = 16'h1000;
        for (int k = 0; k < 25; k++) cycle();
        check("af_unmasked", 32'(af_phase[1]), 32'd0);
        check("af_bit4", 32'(dut.g_pad[1].shreg[4]), 32'd0);
        strobe = 1'b0; af_req = '0;
        cycle();

        // Strobe coincident with a pad0 fall.
        btn = 16'h00A7;
        pulse(2'b01);
        pad_clk[0] = 1'b1;
        cycle();
        pad_clk[0] = 1'b0; strobe = 1'b1;
        cycle();
        strobe = 1'b0;
        check("prio_data", 32'(pad_data[0]), 32'd1);
        check("prio_exh", 32'(pad_exhausted[0]), 32'd0);
        cycle();

        // Independent and simultaneous reads with different buttons per pad.
        btn = 16'h3CA6;
        latch();
        for (int k = 0; k < 20; k++) pulse(2'($urandom_range(1, 3)));

        // Reset in the middle of a read.
        btn = 16'h5A69; af_req = 16'h0302;
        latch();
        for (int k = 0; k < 3; k++) pulse(2'b11);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_mid_data", 32'(pad_data), 32'd0);
        check("rst_mid_exh", 32'(pad_exhausted), 32'd0);
        check("rst_mid_phase", 32'(af_phase), 32'd0);
        model_reset();
        cycle();
        cycle();
        resetn = 1'b1; af_req = '0; btn = 16'hC381;
        latch();
        for (int k = 0; k < BW; k++) pulse(2'b11);
        check("post_rst_exh", 32'(pad_exhausted), 32'd3);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            strobe  = ($urandom_range(0, 11) == 0);
            pad_clk = 2'($urandom);
            if ($urandom_range(0, 31) == 0) btn = 16'($urandom);
            if ($urandom_range(0, 63) == 0)
                af_req = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
